// File: rtl/mu0_sequencer_if.sv
// rtl/mu0_sequencer_if.sv - decoder/memory/debug signal bundle for the MU0 cycle sequencer
interface mu0_sequencer_if #(
  parameter int INSTR_CNT_W = 16,
  parameter int CYCLE_CNT_W = 32
);
  logic [3:0]             IR_OP;
  logic                   EXTRA;
  logic                   MEM_READY;
  logic                   RUN;
  logic                   STEP;
  logic                   FETCH;
  logic                   EXEC1;
  logic                   EXEC2;
  logic                   IR_LOAD;
  logic                   HALTED;
  logic                   PAUSED;
  logic [INSTR_CNT_W-1:0] INSTR_COUNT;
  logic [CYCLE_CNT_W-1:0] CYCLE_COUNT;

  modport master (
    output IR_OP, EXTRA, MEM_READY, RUN, STEP,
    input  FETCH, EXEC1, EXEC2, IR_LOAD, HALTED, PAUSED, INSTR_COUNT, CYCLE_COUNT
  );

  modport slave (
    input  IR_OP, EXTRA, MEM_READY, RUN, STEP,
    output FETCH, EXEC1, EXEC2, IR_LOAD, HALTED, PAUSED, INSTR_COUNT, CYCLE_COUNT
  );
endinterface

// File: rtl/mu0_sequencer.sv
// rtl/mu0_sequencer.sv - MU0 FETCH/EXEC1/EXEC2 phase generator with stall, halt and counters
// Single-step pause/STEP control is built only when MU0_SINGLE_STEP_EN is defined.
module mu0_sequencer #(
  parameter int INSTR_CNT_W = 16,
  parameter int CYCLE_CNT_W = 32
) (
  input  logic           CLOCK,
  input  logic           RESET_N,
  mu0_sequencer_if.slave bus
);

  localparam logic [3:0] OP_STP = 4'b0111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_PAUSE,
    S_HALT
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  state_t                 after_retire;
  logic                   retire;
  logic                   active;
  logic                   pause_exit;
  logic [INSTR_CNT_W-1:0] instr_cnt;
  logic [CYCLE_CNT_W-1:0] cycle_cnt;

`ifdef MU0_SINGLE_STEP_EN
  logic step_q;

  // Sampled every cycle so a STEP edge outside S_PAUSE is simply lost.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) step_q <= 1'b0;
    else          step_q <= bus.STEP;
  end

  assign pause_exit   = bus.RUN | (bus.STEP & ~step_q);
  assign after_retire = bus.RUN ? S_FETCH : S_PAUSE;
  assign bus.PAUSED   = (state == S_PAUSE);
`else
  logic unused_step_ctl;

  assign unused_step_ctl = bus.RUN ^ bus.STEP;
  assign pause_exit      = 1'b1;
  assign after_retire    = S_FETCH;
  assign bus.PAUSED      = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        if (bus.MEM_READY) state_nxt = S_EXEC1;
      end
      S_EXEC1: begin
        // STP wins over EXTRA and never counts as retired.
        if (bus.IR_OP == OP_STP) begin
          state_nxt = S_HALT;
        end else if (bus.EXTRA) begin
          state_nxt = S_EXEC2;
        end else begin
          retire    = 1'b1;
          state_nxt = after_retire;
        end
      end
      S_EXEC2: begin
        if (bus.MEM_READY) begin
          retire    = 1'b1;
          state_nxt = after_retire;
        end
      end
      S_PAUSE: begin
        if (pause_exit) state_nxt = S_FETCH;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  assign active = (state == S_FETCH) || (state == S_EXEC1) || (state == S_EXEC2);

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state     <= S_FETCH;
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (retire) instr_cnt <= instr_cnt + INSTR_CNT_W'(1);
      if (active) cycle_cnt <= cycle_cnt + CYCLE_CNT_W'(1);
    end
  end

  assign bus.FETCH       = (state == S_FETCH);
  assign bus.EXEC1       = (state == S_EXEC1);
  assign bus.EXEC2       = (state == S_EXEC2);
  assign bus.HALTED      = (state == S_HALT);
  assign bus.IR_LOAD     = bus.FETCH & bus.MEM_READY;
  assign bus.INSTR_COUNT = instr_cnt;
  assign bus.CYCLE_COUNT = cycle_cnt;

endmodule

// File: tb/tb_mu0_sequencer.sv
// tb/tb_mu0_sequencer.sv - scoreboard bench for mu0_sequencer with directed phase/counter vectors
module tb_mu0_sequencer;

  // Narrow instruction counter keeps the wrap-around run short.
  localparam int IW = 8;
  localparam int CW = 32;
  localparam int PH_F = 0, PH_E1 = 1, PH_E2 = 2, PH_P = 3, PH_H = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mu0_sequencer_if #(.INSTR_CNT_W(IW), .CYCLE_CNT_W(CW)) bus ();

  mu0_sequencer #(.INSTR_CNT_W(IW), .CYCLE_CNT_W(CW)) dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [5:0]    flags;
    logic [IW-1:0] ic;
    logic [CW-1:0] cc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    exp_ic = 0;
  int    exp_cc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flags = {FETCH, EXEC1, EXEC2, IR_LOAD, HALTED, PAUSED}
  task automatic chk(input string nm, input int ph, input logic irl);
    exp_t e;
    e.flags = {ph == PH_F, ph == PH_E1, ph == PH_E2, irl, ph == PH_H, ph == PH_P};
    e.ic    = IW'(exp_ic);
    e.cc    = CW'(exp_cc);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    exp_t       e;
    string      nm;
    logic [5:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {bus.FETCH, bus.EXEC1, bus.EXEC2, bus.IR_LOAD, bus.HALTED, bus.PAUSED};
      vectors++;
      if (act !== e.flags) begin
        miscompares++;
        $display("FAIL %s flags got %b want %b", nm, act, e.flags);
      end
      vectors++;
      if (bus.INSTR_COUNT !== e.ic) begin
        miscompares++;
        $display("FAIL %s instr_count got %0d want %0d", nm, bus.INSTR_COUNT, e.ic);
      end
      vectors++;
      if (bus.CYCLE_COUNT !== e.cc) begin
        miscompares++;
        $display("FAIL %s cycle_count got %0d want %0d", nm, bus.CYCLE_COUNT, e.cc);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.IR_OP = 4'b0000;
    bus.EXTRA = 1'b0;
    bus.MEM_READY = 1'b1;
    bus.RUN = 1'b1;
    bus.STEP = 1'b0;

    tick(); chk("reset", PH_F, 1'b1);
    tick(); rst_n = 1'b1; chk("reset_hold", PH_F, 1'b1);

    // EXTRA instructions: period-3 FETCH/EXEC1/EXEC2
    bus.EXTRA = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_cc++;
      if (k % 3 == 0) exp_ic++;
      chk("extra_loop", k % 3, (k % 3) == 0);
    end
    tick(); exp_cc++; exp_ic++;
    bus.MEM_READY = 1'b0; bus.EXTRA = 1'b0;
    chk("nine_cycles", PH_F, 1'b0);

    // Four wait cycles in FETCH
    for (int k = 0; k < 3; k++) begin
      tick(); exp_cc++; chk("fetch_stall", PH_F, 1'b0);
    end
    tick(); exp_cc++; bus.MEM_READY = 1'b1; chk("fetch_release", PH_F, 1'b1);
    tick(); exp_cc++; chk("stall_e1", PH_E1, 1'b0);
    tick(); exp_cc++; exp_ic++; chk("stall_retire", PH_F, 1'b1);

    bus.RUN = 1'b0;
    tick(); exp_cc++; chk("e1_run0", PH_E1, 1'b0);
`ifdef MU0_SINGLE_STEP_EN
    tick(); exp_cc++; exp_ic++; chk("paused", PH_P, 1'b0);
    repeat (3) begin tick(); chk("pause_frozen", PH_P, 1'b0); end
    tick(); bus.STEP = 1'b1; chk("step_rise", PH_P, 1'b0);
    tick(); bus.STEP = 1'b0; chk("step_fetch", PH_F, 1'b1);
    tick(); exp_cc++; chk("step_e1", PH_E1, 1'b0);
    tick(); exp_cc++; exp_ic++; chk("step_repaused", PH_P, 1'b0);
    tick(); bus.STEP = 1'b1; chk("hold_start", PH_P, 1'b0);
    tick(); chk("hold_fetch", PH_F, 1'b1);
    tick(); exp_cc++; chk("hold_e1", PH_E1, 1'b0);
    tick(); exp_cc++; exp_ic++; chk("hold_paused", PH_P, 1'b0);
    repeat (6) begin tick(); chk("hold_no_rerun", PH_P, 1'b0); end
    tick(); bus.STEP = 1'b0; chk("hold_release", PH_P, 1'b0);
    tick(); bus.RUN = 1'b1; chk("run_set", PH_P, 1'b0);
    tick(); chk("run_resume", PH_F, 1'b1);
`else
    tick(); exp_cc++; exp_ic++; bus.STEP = 1'b1; chk("no_pause", PH_F, 1'b1);
    tick(); exp_cc++; bus.STEP = 1'b0; chk("no_pause_e1", PH_E1, 1'b0);
    tick(); exp_cc++; exp_ic++; bus.RUN = 1'b1; chk("no_pause_f", PH_F, 1'b1);
`endif

    // Reset while stalled in EXEC2
    bus.EXTRA = 1'b1;
    tick(); exp_cc++; chk("rst_e1", PH_E1, 1'b0);
    tick(); exp_cc++; bus.MEM_READY = 1'b0; chk("rst_e2", PH_E2, 1'b0);
    tick(); exp_cc++; rst_n = 1'b0; chk("rst_e2_stall", PH_E2, 1'b0);
    tick(); rst_n = 1'b1; bus.MEM_READY = 1'b1; bus.EXTRA = 1'b0;
    exp_ic = 0; exp_cc = 0;
    chk("mid_reset", PH_F, 1'b1);

    // Instruction counter wrap: 255 two-cycle instructions, then one more
    for (int i = 0; i < 255; i++) begin
      tick(); exp_cc++;
      tick(); exp_cc++; exp_ic++;
    end
    chk("pre_wrap", PH_F, 1'b1);
    tick(); exp_cc++; chk("wrap_e1", PH_E1, 1'b0);
    tick(); exp_cc++; exp_ic = 0; chk("wrap", PH_F, 1'b1);

    // STP with EXTRA also set: halt, never EXEC2
    tick(); exp_cc++; bus.IR_OP = 4'b0111; bus.EXTRA = 1'b1; chk("stp_e1", PH_E1, 1'b0);
    tick(); exp_cc++; chk("halted", PH_H, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.RUN = i[0]; bus.STEP = i[1]; bus.MEM_READY = i[2];
      chk("halt_frozen", PH_H, 1'b0);
    end
    tick(); rst_n = 1'b0; chk("halt_pre_reset", PH_H, 1'b0);
    tick(); rst_n = 1'b1;
    bus.IR_OP = 4'b0000; bus.EXTRA = 1'b0; bus.MEM_READY = 1'b1; bus.RUN = 1'b1; bus.STEP = 1'b0;
    exp_ic = 0; exp_cc = 0;
    chk("halt_reset", PH_F, 1'b1);
    tick(); exp_cc++; chk("post_halt_e1", PH_E1, 1'b0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
